// File: rtl/load_store_unit.sv
// RV32I load/store stage: accepts an aligned access from the ALU, drives a req/ack data
// memory port with a bounded wait, and returns extended load data for writeback.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lsu_req,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    input  logic [1:0]  i_lsu_size,
    input  logic        i_lsu_unsigned,
    output logic        o_lsu_stall,
    output logic        o_lsu_done,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_misalign,
    output logic        o_lsu_timeout,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_bmask_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        timeout_q;

    logic        misalign_s;
    logic        accept_s;

    // Request qualification: only an aligned request in IDLE is accepted.
    always_comb begin
        misalign_s = 1'b0;
        accept_s   = 1'b0;
        if (state_q == ST_IDLE && i_lsu_req) begin
            misalign_s = is_misaligned(i_lsu_size, i_lsu_addr[1:0]);
            accept_s   = ~misalign_s;
        end else begin
            misalign_s = 1'b0;
            accept_s   = 1'b0;
        end
    end

    // Access FSM with all memory-port and response outputs held in registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_bmask_q <= 4'b0000;
            rdata_q     <= 32'h0000_0000;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= 8'd0;
                        timeout_q   <= 1'b0;
                        off_q       <= i_lsu_addr[1:0];
                        size_q      <= i_lsu_size;
                        uns_q       <= i_lsu_unsigned;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= i_lsu_wren;
                        mem_addr_q  <= {i_lsu_addr[31:2], 2'b00};
                        mem_wdata_q <= lane_wdata(i_lsu_size, i_lsu_wdata);
                        mem_bmask_q <= lane_mask(i_lsu_size, i_lsu_addr[1:0]);
                    end
                end
                ST_WAIT: begin
                    if (i_mem_ack) begin
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        rdata_q   <= mem_we_q ? 32'h0000_0000
                                              : extract_load(i_mem_rdata, size_q, off_q, uns_q);
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        // This cycle completes the last permitted wait cycle.
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        rdata_q   <= 32'h0000_0000;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_lsu_stall    = accept_s | (state_q == ST_WAIT);
    assign o_lsu_misalign = misalign_s;
    assign o_lsu_done     = done_q;
    assign o_lsu_timeout  = timeout_q;
    assign o_lsu_rdata    = rdata_q;
    assign o_mem_req      = mem_req_q;
    assign o_mem_we       = mem_we_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wdata    = mem_wdata_q;
    assign o_mem_bmask    = mem_bmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// checked against an arithmetic model of lane masks, store replication and load extension.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        lsu_req;
    logic        lsu_wren;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;
    logic        lsu_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lsu_req(lsu_req), .i_lsu_wren(lsu_wren), .i_lsu_addr(lsu_addr),
        .i_lsu_wdata(lsu_wdata), .i_lsu_size(lsu_size), .i_lsu_unsigned(lsu_unsigned),
        .o_lsu_stall(lsu_stall), .o_lsu_done(lsu_done), .o_lsu_rdata(lsu_rdata),
        .o_lsu_misalign(lsu_misalign), .o_lsu_timeout(lsu_timeout),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_mask(input logic [31:0] addr, input logic [1:0] size);
        int n;
        logic [31:0] m;
        n = nbytes(size);
        m = 32'(((1 << n) - 1) << (addr % 4));
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [1:0] size);
        int n;
        n = nbytes(size);
        if (n == 1) return (wdata & 32'h0000_00FF) * 32'h0101_0101;
        if (n == 2) return (wdata & 32'h0000_FFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] v;
        logic [31:0] top;
        n = nbytes(size);
        v = rdata >> (8 * (addr % 4));
        if (n < 4) begin
            v = v & ((32'd1 << (8 * n)) - 32'd1);
            top = v >> (8 * n - 1);
            if (!uns && top[0]) v = v - (32'd1 << (8 * n));
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'b11) || ((addr % nbytes(size)) != 0);
    endfunction

    // k = WAIT cycle in which ack arrives (outside 1..TO means no ack -> timeout).
    task automatic do_access(input string tag, input logic wren, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                             input int k, input logic [31:0] mrdata, input logic [3:0] exp_mask,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        int  exp_cycles;
        bit  exp_to;
        int  req_cycles;
        bit  got_done;
        exp_to     = (k < 1) || (k > TO);
        exp_cycles = exp_to ? TO : k;
        req_cycles = 0;
        got_done   = 1'b0;
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_wren = wren; lsu_addr = addr; lsu_wdata = wdata;
        lsu_size = size; lsu_unsigned = uns; mem_ack = 1'b0;
        #2;
        checks++;
        if (lsu_stall !== 1'b1 || lsu_misalign !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: stall=%b misalign=%b req=%b want 1 0 0", tag, lsu_stall, lsu_misalign, mem_req);
        end
        for (int c = 1; c <= TO + 4 && !got_done; c++) begin
            @(posedge clk); #1;
            mem_ack   = (c == k);
            mem_rdata = (c == k) ? mrdata : $urandom;
            #2;
            if (lsu_done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                req_cycles++;
                checks++;
                if (mem_req !== 1'b1 || lsu_stall !== 1'b1 || mem_we !== wren ||
                    mem_addr !== {addr[31:2], 2'b00} || mem_bmask !== exp_mask ||
                    (wren && mem_wdata !== exp_wdata)) begin
                    failures++;
                    $display("FAIL %s wait%0d: req=%b stall=%b we=%b addr=%h mask=%b wdata=%h want 1 1 %b %h %b %h",
                             tag, c, mem_req, lsu_stall, mem_we, mem_addr, mem_bmask, mem_wdata,
                             wren, {addr[31:2], 2'b00}, exp_mask, exp_wdata);
                end
            end
        end
        mem_ack = 1'b0;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL %s done: no done pulse within %0d cycles, want one", tag, TO + 4);
        end else if (lsu_stall !== 1'b0 || mem_req !== 1'b0 || lsu_rdata !== exp_rdata ||
                     lsu_timeout !== exp_to || req_cycles != exp_cycles) begin
            failures++;
            $display("FAIL %s resp: stall=%b req=%b rdata=%h to=%b reqcyc=%0d want 0 0 %h %b %0d",
                     tag, lsu_stall, mem_req, lsu_rdata, lsu_timeout, req_cycles,
                     exp_rdata, exp_to, exp_cycles);
        end
        @(posedge clk); #1;
        lsu_req = 1'b0;
        #2;
        checks++;
        if (lsu_done !== 1'b0 || lsu_stall !== 1'b0 || mem_req !== 1'b0 || lsu_timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: done=%b stall=%b req=%b to=%b want 0 0 0 0", tag, lsu_done, lsu_stall, mem_req, lsu_timeout);
        end
    endtask

    task automatic do_misaligned(input string tag, input logic [31:0] addr, input logic [1:0] size);
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_wren = $urandom_range(0, 1); lsu_addr = addr;
        lsu_size = size; lsu_unsigned = 1'b0; lsu_wdata = $urandom;
        #2;
        checks++;
        if (lsu_misalign !== 1'b1 || lsu_stall !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s: misalign=%b stall=%b req=%b want 1 0 0", tag, lsu_misalign, lsu_stall, mem_req);
        end
        @(posedge clk); #1;
        lsu_req = 1'b0;
        #2;
        checks++;
        if (mem_req !== 1'b0 || lsu_done !== 1'b0 || lsu_misalign !== 1'b0) begin
            failures++;
            $display("FAIL %s after: req=%b done=%b misalign=%b want 0 0 0", tag, mem_req, lsu_done, lsu_misalign);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || lsu_done !== 1'b0 || lsu_timeout !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || lsu_rdata !== 32'h0 || mem_bmask !== 4'h0 ||
            lsu_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset: req=%b we=%b done=%b to=%b addr=%h wd=%h rd=%h mask=%b stall=%b want all 0",
                     mem_req, mem_we, lsu_done, lsu_timeout, mem_addr, mem_wdata, lsu_rdata, mem_bmask, lsu_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_access("word_store", 1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 2, 32'h0,
                  4'b1111, 32'hDEADBEEF, 32'h0);
        do_access("lb", 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 1, 32'h80FF_1234,
                  4'b1000, 32'h0, 32'hFFFF_FF80);
        do_access("lbu", 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 3, 32'h80FF_1234,
                  4'b1000, 32'h0, 32'h0000_0080);
        do_access("lh", 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 1, 32'h8001_7FFF,
                  4'b1100, 32'h0, 32'hFFFF_8001);
        do_access("sh", 1'b1, 32'h102, 32'h1234ABCD, 2'b01, 1'b0, 4, 32'h0,
                  4'b1100, 32'hABCDABCD, 32'h0);
    endtask

    task automatic test_misaligned();
        do_misaligned("mis_word", 32'h101, 2'b10);
        do_misaligned("mis_half", 32'h003, 2'b01);
        do_misaligned("mis_size3", 32'h000, 2'b11);
    endtask

    task automatic test_timeout_reset();
        do_access("timeout", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 0, 32'h0, 4'b1111, 32'h0, 32'h0);
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_wren = 1'b0; lsu_addr = 32'h200; lsu_size = 2'b10; mem_ack = 1'b0;
        @(posedge clk); #1;
        lsu_req = 1'b0;
        @(posedge clk); #3;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid pre: req=%b want 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || lsu_done !== 1'b0 || lsu_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid drop: req=%b done=%b stall=%b want 0 0 0", mem_req, lsu_done, lsu_stall);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #3;
        checks++;
        if (mem_req !== 1'b0 || lsu_stall !== 1'b0 || lsu_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid idle: req=%b stall=%b done=%b want 0 0 0", mem_req, lsu_stall, lsu_done);
        end
        do_access("post_rst", 1'b0, 32'h204, 32'h0, 2'b10, 1'b0, 1, 32'h1357_9BDF,
                  4'b1111, 32'h0, 32'h1357_9BDF);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic        wren;
        logic        uns;
        int          k;
        for (int i = 0; i < 40; i++) begin
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            size  = 2'($urandom_range(0, 3));
            wren  = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            k     = $urandom_range(0, TO + 2);
            if (model_misaligned(addr, size)) begin
                do_misaligned("rnd_mis", addr, size);
            end else begin
                do_access("rnd", wren, addr, wdata, size, uns, k, rdata,
                          model_mask(addr, size), model_wdata(wdata, size),
                          (wren || k < 1 || k > TO) ? 32'h0 : model_load(rdata, addr, size, uns));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; lsu_req = 1'b0; lsu_wren = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        lsu_size = 2'b00; lsu_unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage directly downstream of the ALU in the RV32I core. Takes the ALU result as the effective address and performs byte/half/word loads and stores against a variable-latency data memory with a req/ack handshake. Stalls the core while an access is in flight. Returns aligned, sign- or zero-extended load data for writeback.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, maximum number of WAIT cycles without `i_mem_ack` before the access is aborted (1..255)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_lsu_req  in  1  load/store instruction present this cycle
- i_lsu_wren  in  1  1 = store, 0 = load
- i_lsu_addr  in  32  effective address (ALU `o_alu_data`)
- i_lsu_wdata  in  32  store data (rs2)
- i_lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_lsu_unsigned  in  1  1 = zero-extend load (LBU/LHU)
- o_lsu_stall  out  1  hold PC and register writes
- o_lsu_done  out  1  one-cycle pulse: access complete, `o_lsu_rdata` valid
- o_lsu_rdata  out  32  extended load data; 0 for stores
- o_lsu_misalign  out  1  combinational flag: request rejected, no memory access
- o_lsu_timeout  out  1  accompanies `o_lsu_done` when the access was aborted
- o_mem_req  out  1  memory request, held until ack
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  32  word address `{addr[31:2],2'b00}`
- o_mem_wdata  out  32  lane-replicated store data
- o_mem_bmask  out  4  byte-lane enables
- i_mem_ack  in  1  memory completion, 1 cycle
- i_mem_rdata  in  32  read word, valid with `i_mem_ack`

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If `i_lsu_req` is set and the access is aligned: latch address, size, unsigned, wren, mask and wdata; clear the timeout counter; go to WAIT.
  - Misaligned: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11.
  - A misaligned request asserts `o_lsu_misalign` in the same cycle, with no stall, no memory request and no state change.
- **WAIT**
  - `o_mem_req`=1 and all memory outputs are stable from latched registers.
  - On `i_mem_ack`: capture the load result into `o_lsu_rdata` (0 for stores) and go to RESP.
  - The counter increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES: drop the request, set `o_lsu_rdata`=0, set the timeout flag, and go to RESP.
- **RESP**
  - `o_lsu_done`=1, `o_lsu_stall`=0, and `o_lsu_timeout` shows the flag. The core commits at the end of this cycle.
  - `i_lsu_req` is ignored in RESP, since the same instruction is still presented. Go to IDLE.
- `o_lsu_stall` = (IDLE & `i_lsu_req` & aligned) | WAIT.
- Byte mask:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: wdata
- Load extraction:
  - Shift `i_mem_rdata` right by `8*addr[1:0]`, then take 8 or 16 bits.
  - Extend with bit 7 or bit 15 unless `i_lsu_unsigned` is set. Word loads are passed through.
- `i_mem_ack` is ignored in IDLE and RESP.

## Timing
- Reset (asynchronous):
  - State goes to IDLE; counter and timeout flag go to 0.
  - `o_mem_req`, `o_mem_we`, `o_lsu_done`, `o_lsu_timeout` = 0.
  - `o_mem_addr`, `o_mem_wdata`, `o_lsu_rdata` = 0; `o_mem_bmask` = 0.
  - Reset mid-access drops `o_mem_req` immediately; the access is abandoned.
- Minimum access is 3 cycles, with ack in the first WAIT cycle:
  - cycle 0: IDLE, stall=1
  - cycle 1: WAIT, `o_mem_req`=1, ack=1
  - cycle 2: RESP, done=1
- An ack after k WAIT cycles gives a total latency of k+2 cycles.
- Timeout: `o_mem_req` is high for exactly TIMEOUT_CYCLES cycles, then RESP follows.
- A new request is accepted at the earliest in the cycle after RESP.
- `o_mem_req` never toggles low between accept and ack/timeout.

## Test plan
- **Word store:** addr 0x100, wdata 0xDEADBEEF, ack after 2 WAIT cycles.
  - Expect: `o_mem_addr`=0x100, bmask=1111, we=1, stall high for 3 cycles, then done pulse with rdata=0.
- **Signed byte load:** addr 0x103, `i_mem_rdata` 0x80FF_1234.
  - Expect: `o_lsu_rdata`=0xFFFFFF80.
  - Same with `i_lsu_unsigned`=1: expect 0x00000080.
- **Signed half load:** addr 0x102, rdata 0x8001_7FFF.
  - Expect: `o_lsu_rdata`=0xFFFF8001.
- **Half store:** addr 0x102, wdata 0x1234ABCD.
  - Expect: bmask=1100, `o_mem_wdata`=0xABCDABCD.
- **Misaligned and illegal requests:** word load at 0x101; half at 0x003; size 11.
  - Expect: `o_lsu_misalign`=1 same cycle, stall=0, `o_mem_req` stays 0.
- **Timeout and reset recovery:** TIMEOUT_CYCLES=4, no ack.
  - Expect: `o_mem_req` high exactly 4 cycles, then done=1 and timeout=1, rdata=0.
  - Then assert reset mid-WAIT. Expect: `o_mem_req` drops asynchronously and the FSM is in IDLE after release.
